// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: central stall/flush sequencer for the five-stage cached pipeline.
// It owns the run/wait/halt state, the deferred branch redirect and a saturating
// stall-cycle counter. All control outputs are combinational from that state and
// the current hazard inputs.
module pipe_stall_ctrl #(
  parameter int unsigned PC_W  = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_stall,
  input  logic             d_stall,
  input  logic             ld_use,
  input  logic             br_taken,
  input  logic [PC_W-1:0]  br_target,
  input  logic             halt,
  input  logic             cnt_clr,
  output logic             pc_wen,
  output logic             pc_sel,
  output logic [PC_W-1:0]  pc_redir,
  output logic             ifid_stall,
  output logic             idex_stall,
  output logic             exmem_stall,
  output logic             memwb_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_IWAIT  = 2'd1;
  localparam logic [1:0] ST_DWAIT  = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic             redir_pend_q, redir_pend_d;
  logic [PC_W-1:0]  redir_pc_q, redir_pc_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // State register, deferred redirect and stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  // Priority resolution of hazards into pipeline controls and next state
  always_comb begin
    state_d      = ST_RUN;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;
    pc_wen       = 1'b0;
    pc_sel       = 1'b0;
    pc_redir     = redir_pc_q;
    ifid_stall   = 1'b0;
    idex_stall   = 1'b0;
    exmem_stall  = 1'b0;
    memwb_stall  = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_flush  = 1'b0;

    if (state_q == ST_HALTED || halt) begin
      // Halt freezes every stage; only reset leaves this state
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_stall = 1'b1;
      memwb_stall = 1'b1;
      state_d     = ST_HALTED;
    end else if (d_stall) begin
      // MEM outstanding: freeze front end, bubble into WB; EX re-presents its branch later
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_stall = 1'b1;
      memwb_flush = 1'b1;
      state_d     = ST_DWAIT;
    end else if (br_taken && !i_stall) begin
      pc_wen     = 1'b1;
      pc_sel     = 1'b1;
      pc_redir   = br_target;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (br_taken) begin
      // Fetch still outstanding: remember the target, apply once IF is free
      redir_pc_d   = br_target;
      redir_pend_d = 1'b1;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      state_d      = ST_IWAIT;
    end else if (ld_use) begin
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
    end else if (i_stall) begin
      ifid_flush = 1'b1;
      state_d    = ST_IWAIT;
    end else begin
      pc_wen = 1'b1;
      if (redir_pend_q) begin
        // First free cycle after capture: steer PC and drop the wrong-path fetch
        pc_sel       = 1'b1;
        ifid_flush   = 1'b1;
        redir_pend_d = 1'b0;
      end
    end
  end

  // Saturating count of PC-hold cycles outside HALTED; clear wins
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
    end else if (!pc_wen && state_d != ST_HALTED && stall_cnt_q != CNT_MAX) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;

endmodule
